// File: rtl/f2f_sched_pkg.sv
// Shared types and constants for the fixed-to-float lane scheduler.
// The tag and FIFO entry types carry the lane index sized for N_LANES_CFG;
// the scheduler's N_LANES parameter is expected to match it.
package f2f_sched_pkg;

   localparam int unsigned FIXED_W     = 43;
   localparam int unsigned FLOAT_W     = 16;
   localparam int unsigned CONV_LAT    = 6;
   localparam int unsigned N_LANES_CFG = 4;

   // Width of a lane index; never narrower than one bit
   function automatic int unsigned lane_w(input int unsigned n);
      return (n > 32'd1) ? $clog2(n) : 32'd1;
   endfunction

   localparam int unsigned LANE_W = lane_w(N_LANES_CFG);

   // One converter slot: is it occupied, and by which lane
   typedef struct packed {
      logic              vld;
      logic [LANE_W-1:0] lane;
   } f2f_tag_t;

   // One buffered result
   typedef struct packed {
      logic [LANE_W-1:0]  lane;
      logic [FLOAT_W-1:0] data;
   } f2f_entry_t;

endpackage

// File: rtl/f2f_rr_arbiter.sv
// Round-robin arbiter: picks the first requesting lane at or after the
// pointer, wrapping, and advances the pointer past the winner on a grant.
module f2f_rr_arbiter
   import f2f_sched_pkg::*;
#(
   parameter  int unsigned N_LANES = 4,
   localparam int unsigned IW      = lane_w(N_LANES)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N_LANES-1:0] req_i,
   input  logic               en_i,
   output logic [N_LANES-1:0] grant_o,
   output logic [IW-1:0]      idx_o,
   output logic               issue_o
);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] ptr_d;
   logic [IW-1:0] pick_s;
   logic          found_s;

   // Scan lanes starting at the pointer; the first requester wins
   always_comb begin
      int unsigned sum_v;
      int unsigned cand_v;
      logic        hit_v;
      pick_s  = '0;
      found_s = 1'b0;
      sum_v   = 32'd0;
      cand_v  = 32'd0;
      hit_v   = 1'b0;
      for (int unsigned off = 0; off < N_LANES; off++) begin
         sum_v   = 32'(ptr_q) + off;
         cand_v  = (sum_v >= N_LANES) ? (sum_v - N_LANES) : sum_v;
         hit_v   = req_i[IW'(cand_v)] && !found_s;
         pick_s  = hit_v ? IW'(cand_v) : pick_s;
         found_s = found_s | hit_v;
      end
   end

   // Grant only when enabled; pointer moves just past the granted lane
   always_comb begin
      issue_o = en_i & found_s;
      idx_o   = pick_s;
      grant_o = issue_o ? (N_LANES'(1) << pick_s) : '0;
      if (!issue_o) begin
         ptr_d = ptr_q;
      end else if (pick_s == IW'(N_LANES - 1)) begin
         ptr_d = '0;
      end else begin
         ptr_d = pick_s + IW'(1);
      end
   end

   // Round-robin pointer register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/f2f_sched_chk.sv
// Property checks for the lane scheduler: credit must prevent FIFO overflow,
// the grant must be one-hot or idle, and in-flight slots never exceed the pipe.
module f2f_sched_chk
   import f2f_sched_pkg::*;
#(
   parameter int unsigned N_LANES    = 4,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CNT_W      = 4,
   parameter int unsigned INF_W      = 3
) (
   input logic               clk,
   input logic               reset_n,
   input logic               push_i,
   input logic [CNT_W-1:0]   fifo_cnt_i,
   input logic [INF_W-1:0]   inflight_i,
   input logic [N_LANES-1:0] grant_i
);

   a_no_push_when_full: assert property (
      @(posedge clk) disable iff (!reset_n)
      !(push_i && (fifo_cnt_i == CNT_W'(FIFO_DEPTH))))
      else $error("f2f_sched_chk: push into a full result FIFO");

   a_grant_onehot0: assert property (
      @(posedge clk) disable iff (!reset_n)
      $onehot0(grant_i))
      else $error("f2f_sched_chk: more than one lane granted");

   a_inflight_range: assert property (
      @(posedge clk) disable iff (!reset_n)
      (inflight_i <= INF_W'(CONV_LAT)))
      else $error("f2f_sched_chk: in-flight count beyond converter depth");

endmodule

// File: rtl/f2f_lane_scheduler.sv
// Shares one fixed-latency fixed-to-float converter among N_LANES lanes.
// A tag pipe follows each converter slot so results can be labelled with
// their lane; a credit-protected FWFT FIFO absorbs downstream backpressure.
// Credit = FIFO_DEPTH - (in flight + buffered), so every issued value is
// guaranteed a FIFO slot when it leaves the non-stallable converter.
module f2f_lane_scheduler
   import f2f_sched_pkg::*;
#(
   parameter  int unsigned N_LANES    = N_LANES_CFG,
   parameter  int unsigned FIFO_DEPTH = 8,
   localparam int unsigned LW         = lane_w(N_LANES)
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [N_LANES-1:0]         req_valid,
   input  logic [N_LANES*FIXED_W-1:0] req_data,
   output logic [N_LANES-1:0]         req_ready,
   output logic [FIXED_W-1:0]         cv_fixed_out,
   input  logic [FLOAT_W-1:0]         cv_float_in,
   output logic                       out_valid,
   output logic [FLOAT_W-1:0]         out_data,
   output logic [LW-1:0]              out_lane,
   input  logic                       out_ready,
   output logic                       busy
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 32'd1) ? $clog2(FIFO_DEPTH) : 32'd1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned INF_W = $clog2(CONV_LAT + 1);
   localparam int unsigned SUM_W = CNT_W + 1;

   // FIFO pointer increment with wrap for non-power-of-two depths
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(FIFO_DEPTH - 1)) begin
         return '0;
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   logic               credit_s;
   logic               en_s;
   logic               issue_s;
   logic [LW-1:0]      idx_s;
   logic [N_LANES-1:0] grant_s;
   logic               push_s;
   logic               pop_s;
   f2f_tag_t           tag_d;
   f2f_tag_t           tag_q [CONV_LAT];
   f2f_entry_t         mem_q [FIFO_DEPTH];
   f2f_entry_t         head_s;
   logic [INF_W-1:0]   inflight_q;
   logic [INF_W-1:0]   inflight_d;
   logic [CNT_W-1:0]   fifo_cnt_q;
   logic [CNT_W-1:0]   fifo_cnt_d;
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_d;

   // Credit uses registered counts only, and nothing is granted while in reset
   always_comb begin
      credit_s = (SUM_W'(inflight_q) + SUM_W'(fifo_cnt_q)) < SUM_W'(FIFO_DEPTH);
      en_s     = reset_n & credit_s;
   end

   f2f_rr_arbiter #(
      .N_LANES (N_LANES)
   ) u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req_i   (req_valid),
      .en_i    (en_s),
      .grant_o (grant_s),
      .idx_o   (idx_s),
      .issue_o (issue_s)
   );

   // Grant and converter input: granted lane's data, zero when idle
   always_comb begin
      req_ready = grant_s;
      if (issue_s) begin
         cv_fixed_out = req_data[32'(idx_s) * FIXED_W +: FIXED_W];
      end else begin
         cv_fixed_out = '0;
      end
      tag_d.vld  = issue_s;
      tag_d.lane = idx_s;
   end

   // Tag pipe: its last stage lines up with the value on cv_float_in
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < CONV_LAT; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         tag_q[0] <= tag_d;
         for (int i = 1; i < CONV_LAT; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   // Push converter results that carry a valid tag; pop on downstream accept
   always_comb begin
      push_s = tag_q[CONV_LAT-1].vld;
      pop_s  = (fifo_cnt_q != '0) & out_ready;
   end

   // Next-state for in-flight count, FIFO occupancy and pointers
   always_comb begin
      case ({issue_s, push_s})
         2'b10:   inflight_d = inflight_q + INF_W'(1);
         2'b01:   inflight_d = inflight_q - INF_W'(1);
         default: inflight_d = inflight_q;
      endcase
      case ({push_s, pop_s})
         2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
         2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
      if (push_s) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // Counter and pointer registers; reset discards everything in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inflight_q <= '0;
         fifo_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         inflight_q <= inflight_d;
         fifo_cnt_q <= fifo_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // FIFO storage: write the labelled result at the tail
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push_s) begin
         mem_q[wr_ptr_q] <= '{lane: tag_q[CONV_LAT-1].lane, data: cv_float_in};
      end
   end

   // First-word-fall-through head; outputs forced to zero when empty
   always_comb begin
      head_s    = mem_q[rd_ptr_q];
      out_valid = (fifo_cnt_q != '0);
      busy      = (fifo_cnt_q != '0) || (inflight_q != '0);
      if (out_valid) begin
         out_data = head_s.data;
         out_lane = head_s.lane;
      end else begin
         out_data = '0;
         out_lane = '0;
      end
   end

   f2f_sched_chk #(
      .N_LANES    (N_LANES),
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W),
      .INF_W      (INF_W)
   ) u_chk (
      .clk        (clk),
      .reset_n    (reset_n),
      .push_i     (push_s),
      .fifo_cnt_i (fifo_cnt_q),
      .inflight_i (inflight_q),
      .grant_i    (grant_s)
   );

endmodule
